// File: rtl/sprite_row_fetcher.sv
// Sprite ROM reader: fetches one 64-pixel row as 16 words and streams 3-bit pixels over valid/ready.
// First pixel ROM_LAT+3 cycles after acceptance, then one per cycle; pix_ready_i low stalls the unpacker,
// the word FIFO fills and address issue pauses. Horizontal mirroring is built only with SPRITE_MIRROR_EN.
module sprite_row_fetcher #(
    parameter int ROM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [2:0]  req_sprite_i,
    input  logic [5:0]  req_row_i,
    input  logic        req_flip_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  sprite_sel_o,
    output logic [9:0]  word_addr_o,
    input  logic [15:0] data_i,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [2:0]  pix_rgb_o,
    output logic [5:0]  pix_x_o,
    output logic        pix_last_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sprite_q, sprite_d;
    logic [5:0]       row_q, row_d;
    logic [4:0]       issued_q, issued_d;
    logic [9:0]       addr_q, addr_d;
    logic [ROM_LAT:0] pipe_q, pipe_d;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      word_q, word_d;
    logic             pix_vld_q, pix_vld_d;
    logic [1:0]       sub_q, sub_d;
    logic [5:0]       x_q, x_d;

    logic             accept, issue, wr_en, rd_en, hs, last_pix;
    logic             flip, cur_flip;
    logic [3:0]       issue_cnt, idx;
    logic [5:0]       cur_row;
    logic [1:0]       psel;
    logic [15:0]      wr_dat;
    logic [3:0]       unused_bits;
    int               occ;

`ifdef SPRITE_MIRROR_EN
    logic flip_q, flip_d;
    assign flip = flip_q;
`else
    logic unused_flip;
    assign flip        = 1'b0;
    assign unused_flip = req_flip_i;
`endif

    // Separator bits of each packed word carry no colour.
    assign unused_bits = {word_q[12], word_q[8], word_q[4], word_q[0]};

    always_comb begin
        // Words already owed to the FIFO: stored plus still travelling through the ROM.
        occ = int'(cnt_q);
        for (int i = 0; i <= ROM_LAT; i++) begin
            occ = occ + int'(pipe_q[i]);
        end

        accept   = req_i && (state_q == IDLE);
        cur_flip = flip;
`ifdef SPRITE_MIRROR_EN
        if (accept) cur_flip = req_flip_i;
        flip_d = accept ? req_flip_i : flip_q;
`endif
        issue     = accept || ((state_q == FETCH) && (issued_q < 5'd16) && (occ < FIFO_DEPTH));
        issue_cnt = accept ? 4'd0 : issued_q[3:0];
        idx       = issue_cnt ^ {4{cur_flip}};
        cur_row   = accept ? req_row_i : row_q;

        state_d  = state_q;
        sprite_d = sprite_q;
        row_d    = row_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        if (accept) begin
            state_d  = FETCH;
            sprite_d = req_sprite_i;
            row_d    = req_row_i;
        end
        if (issue) begin
            addr_d   = {cur_row, idx};
            issued_d = {1'b0, issue_cnt} + 5'd1;
            if (!accept && issued_q == 5'd15) state_d = DRAIN;
        end
        pipe_d = {pipe_q[ROM_LAT-1:0], issue};

        // The top pipe bit lines up with the ROM word for that address.
        wr_en    = pipe_q[ROM_LAT];
        wr_dat   = (sprite_q == 3'd7) ? 16'h0000 : data_i;
        hs       = pix_vld_q && pix_ready_i;
        last_pix = (x_q == 6'd63);
        rd_en    = (cnt_q != '0) && (!pix_vld_q || (hs && sub_q == 2'd3));
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr_en) - CW'(rd_en);

        word_d    = word_q;
        pix_vld_d = pix_vld_q;
        sub_d     = sub_q;
        x_d       = x_q;
        if (hs) begin
            sub_d = sub_q + 2'd1;
            if (sub_q == 2'd3) pix_vld_d = 1'b0;
            if (!last_pix) x_d = x_q + 6'd1;
        end
        if (rd_en) begin
            word_d    = mem_q[rd_ptr_q];
            pix_vld_d = 1'b1;
            sub_d     = 2'd0;
        end
        if (accept) x_d = 6'd0;

        done_o = hs && last_pix;
        if (done_o) state_d = IDLE;

        psel = sub_q ^ {2{flip}};
        case (psel)
            2'd0:    pix_rgb_o = word_q[15:13];
            2'd1:    pix_rgb_o = word_q[11:9];
            2'd2:    pix_rgb_o = word_q[7:5];
            default: pix_rgb_o = word_q[3:1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sprite_q  <= 3'd0;
            row_q     <= 6'd0;
            issued_q  <= 5'd0;
            addr_q    <= 10'd0;
            pipe_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            word_q    <= 16'd0;
            pix_vld_q <= 1'b0;
            sub_q     <= 2'd0;
            x_q       <= 6'd0;
`ifdef SPRITE_MIRROR_EN
            flip_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sprite_q  <= sprite_d;
            row_q     <= row_d;
            issued_q  <= issued_d;
            addr_q    <= addr_d;
            pipe_q    <= pipe_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            pix_vld_q <= pix_vld_d;
            sub_q     <= sub_d;
            x_q       <= x_d;
`ifdef SPRITE_MIRROR_EN
            flip_q    <= flip_d;
`endif
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign busy_o       = (state_q != IDLE);
    assign sprite_sel_o = sprite_q;
    assign word_addr_o  = addr_q;
    assign pix_valid_o  = pix_vld_q;
    assign pix_x_o      = x_q;
    assign pix_last_o   = pix_vld_q && last_pix;
endmodule
